// File: rtl/dm_mmio_bus_pkg.sv
// dm_mmio_bus_pkg
// Shared constants for the data-side memory/MMIO stage:
//   - MMIO_HI   : addr[31:16] value that selects the MMIO region
//   - OFS_*     : MMIO register offsets (addr[7:0])
//   - EN/AR/FLAG/IE : bit positions inside the timer CTRL register
package dm_mmio_bus_pkg;

    localparam logic [15:0] MMIO_HI = 16'hFFFF;

    localparam logic [7:0] OFS_LED   = 8'h00;
    localparam logic [7:0] OFS_SW    = 8'h04;
    localparam logic [7:0] OFS_CTRL  = 8'h08;
    localparam logic [7:0] OFS_LOAD  = 8'h0C;
    localparam logic [7:0] OFS_COUNT = 8'h10;
    localparam logic [7:0] OFS_SEG   = 8'h14;

    localparam int EN   = 0;  // timer enable
    localparam int AR   = 1;  // autoreload
    localparam int FLAG = 2;  // expiry flag, write-1-to-clear
    localparam int IE   = 3;  // interrupt enable

endpackage

// File: rtl/dm_mmio_bus_timer.sv
// mmio_timer
// Down-counting timer with expiry flag and interrupt.
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   ctrl_we       : decoded write strobe for CTRL
//   load_we       : decoded write strobe for LOAD
//   wdata         : store data from the core
//   ctrl_q        : CTRL readback {28'b0, ie, flag, ar, en}
//   load_q        : LOAD register
//   count_q       : current count
//   irq           : flag & ie
module mmio_timer
    import dm_mmio_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_we,
    input  logic        load_we,
    input  logic [31:0] wdata,
    output logic [31:0] ctrl_q,
    output logic [31:0] load_q,
    output logic [31:0] count_q,
    output logic        irq
);

    logic en_q;
    logic ar_q;
    logic ie_q;
    logic flag_q;
    logic expire;
    logic dec;

    // Timer evaluation uses the registered en, so a CTRL write that sets en
    // only starts counting from the following edge.
    assign expire = en_q && (count_q == 32'd0);
    assign dec    = en_q && (count_q != 32'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q    <= 1'b0;
            ar_q    <= 1'b0;
            ie_q    <= 1'b0;
            flag_q  <= 1'b0;
            load_q  <= 32'd0;
            count_q <= 32'd0;
        end else begin
            // CTRL write takes priority over the one-shot auto-clear of en.
            if (ctrl_we) begin
                en_q <= wdata[EN];
                ar_q <= wdata[AR];
                ie_q <= wdata[IE];
            end else if (expire && !ar_q) begin
                en_q <= 1'b0;
            end

            // Hardware set beats a same-cycle W1C.
            if (expire) begin
                flag_q <= 1'b1;
            end else if (ctrl_we && wdata[FLAG]) begin
                flag_q <= 1'b0;
            end

            if (load_we) begin
                load_q <= wdata;
            end

            // A LOAD write beats both decrement and reload.
            if (load_we) begin
                count_q <= wdata;
            end else if (dec) begin
                count_q <= count_q - 32'd1;
            end else if (expire && ar_q) begin
                count_q <= load_q;
            end
        end
    end

    assign ctrl_q = {28'd0, ie_q, flag_q, ar_q, en_q};
    assign irq    = flag_q & ie_q;

endmodule

// File: rtl/dm_mmio_bus.sv
// dm_mmio_bus
// Data-side stage behind a single-cycle core: word RAM plus a small MMIO
// region (LED, SEG, synchronised switches, timer). Reads are combinational
// from addr; writes commit on the rising edge where MemWrite is high.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   MemWrite        : store strobe
//   addr, writedata : byte address and store data
//   readdata        : combinational load data
//   sw_i            : asynchronous switch inputs
//   led_o, seg_o    : output registers
//   irq_o           : timer interrupt
//   dbg_sel/dbg_data: combinational RAM peek by word index
module dm_mmio_bus
    import dm_mmio_bus_pkg::*;
#(
    parameter int          DM_AW   = 10,
    parameter int          SW_W    = 16,
    parameter int          LED_W   = 16,
    parameter logic [15:0] MMIO_HI = dm_mmio_bus_pkg::MMIO_HI
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemWrite,
    input  logic [31:0]      addr,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [SW_W-1:0]  sw_i,
    output logic [LED_W-1:0] led_o,
    output logic [31:0]      seg_o,
    output logic             irq_o,
    input  logic [DM_AW-1:0] dbg_sel,
    output logic [31:0]      dbg_data
);

    logic [31:0]      ram [2**DM_AW];
    logic [DM_AW-1:0] ram_idx;
    logic             is_mmio;
    logic             page_ok;
    logic [7:0]       offset;
    logic             mmio_we;
    logic             led_we;
    logic             seg_we;
    logic             ctrl_we;
    logic             load_we;
    logic [SW_W-1:0]  sw_s1;
    logic [SW_W-1:0]  sw_s2;
    logic [31:0]      ctrl_q;
    logic [31:0]      load_q;
    logic [31:0]      count_q;
    logic             unused_addr;

    // Byte lane bits are ignored: every access is a full word.
    assign unused_addr = ^addr[1:0];

    // RAM index drops the high bits, so RAM aliases across non-MMIO space.
    assign ram_idx = addr[DM_AW+1:2];
    assign is_mmio = (addr[31:16] == MMIO_HI);
    assign page_ok = (addr[15:8] == 8'd0);
    assign offset  = addr[7:0];

    assign mmio_we = MemWrite && is_mmio && page_ok;
    assign led_we  = mmio_we && (offset == OFS_LED);
    assign seg_we  = mmio_we && (offset == OFS_SEG);
    assign ctrl_we = mmio_we && (offset == OFS_CTRL);
    assign load_we = mmio_we && (offset == OFS_LOAD);

    // RAM has no reset; writes are still suppressed while rst is low.
    always_ff @(posedge clk) begin
        if (rst && MemWrite && !is_mmio) begin
            ram[ram_idx] <= writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            led_o <= '0;
            seg_o <= 32'd0;
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= sw_i;
            sw_s2 <= sw_s1;
            if (led_we) begin
                led_o <= writedata[LED_W-1:0];
            end
            if (seg_we) begin
                seg_o <= writedata;
            end
        end
    end

    mmio_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .ctrl_we (ctrl_we),
        .load_we (load_we),
        .wdata   (writedata),
        .ctrl_q  (ctrl_q),
        .load_q  (load_q),
        .count_q (count_q),
        .irq     (irq_o)
    );

    always_comb begin
        readdata = 32'd0;
        if (!is_mmio) begin
            readdata = ram[ram_idx];
        end else if (page_ok) begin
            case (offset)
                OFS_LED:   readdata = 32'(led_o);
                OFS_SW:    readdata = 32'(sw_s2);
                OFS_CTRL:  readdata = ctrl_q;
                OFS_LOAD:  readdata = load_q;
                OFS_COUNT: readdata = count_q;
                OFS_SEG:   readdata = seg_o;
                default:   readdata = 32'd0;
            endcase
        end
    end

    assign dbg_data = ram[dbg_sel];

endmodule
